// File: rtl/costas_loop_ctrl_if.sv
// Handshake and data bundle between the Costas loop controller, the I/Q
// summation blocks and the loop filter.
interface costas_loop_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                     enable;
  logic                     sample_valid;
  logic                     dump;
  logic                     sum_valid;
  logic signed [DATA_W-1:0] sum_i;
  logic signed [DATA_W-1:0] sum_q;
  logic                     filter_update;
  logic                     filter_clear;
  logic                     gain_sel;
  logic                     locked;
  logic [1:0]               state;

  modport master (
    output enable, sample_valid, sum_valid, sum_i, sum_q,
    input  dump, filter_update, filter_clear, gain_sel, locked, state
  );

  modport slave (
    input  enable, sample_valid, sum_valid, sum_i, sum_q,
    output dump, filter_update, filter_clear, gain_sel, locked, state
  );
endinterface

// File: rtl/costas_loop_ctrl.sv
// Costas loop epoch sequencer and lock supervisor.
// Counts samples into integration epochs, strobes dump to the I/Q summers,
// judges each dumped I/Q pair for phase lock and steers the loop filter
// (update, clear, wide/narrow gain) through IDLE / PULL_IN / LOCKED.
module costas_loop_ctrl #(
  parameter int EPOCH_LEN  = 10000,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 4,
  parameter int LOCK_SHIFT = 2,
  parameter int MIN_AMP    = 1024
) (
  input logic              clk,
  input logic              rst,
  costas_loop_ctrl_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int AMP_W  = DATA_W + 1;
  localparam int SHL_W  = AMP_W + LOCK_SHIFT;
  localparam int PASS_W = $clog2(LOCK_COUNT + 1);
  localparam int FAIL_W = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PULL_IN = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  // Magnitude one bit wider than the input so that -2^31 maps to +2^31.
  function automatic logic [AMP_W-1:0] abs_amp(input logic signed [DATA_W-1:0] x);
    logic signed [AMP_W-1:0] ext;
    ext = {x[DATA_W-1], x};
    return ext[AMP_W-1] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  // Phase-lock test: I must be large enough and dominate the scaled Q.
  function automatic logic epoch_pass(input logic signed [DATA_W-1:0] i_sum,
                                      input logic signed [DATA_W-1:0] q_sum);
    logic [AMP_W-1:0] ai;
    logic [AMP_W-1:0] aq;
    logic [SHL_W-1:0] qs;
    ai = abs_amp(i_sum);
    aq = abs_amp(q_sum);
    qs = SHL_W'(aq) << LOCK_SHIFT;
    return (ai >= AMP_W'(MIN_AMP)) && (SHL_W'(ai) > qs);
  endfunction

  function automatic logic [PASS_W-1:0] pass_inc(input logic [PASS_W-1:0] c);
    return (c >= PASS_W'(LOCK_COUNT)) ? c : c + PASS_W'(1);
  endfunction

  function automatic logic [FAIL_W-1:0] fail_inc(input logic [FAIL_W-1:0] c);
    return (c >= FAIL_W'(LOSS_COUNT)) ? c : c + FAIL_W'(1);
  endfunction

  state_t              state_q, state_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [PASS_W-1:0]   pass_q, pass_nxt, pass_up;
  logic [FAIL_W-1:0]   fail_q, fail_nxt, fail_up;
  logic                pass_p0;
  logic                dump_nxt, clear_nxt, vld_nxt;
  logic                dump_p1, clear_p1, vld_p1;

  // Next-state, counter and strobe decode for the current cycle.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pass_nxt  = pass_q;
    fail_nxt  = fail_q;
    dump_nxt  = 1'b0;
    clear_nxt = 1'b0;
    vld_nxt   = 1'b0;
    pass_p0   = epoch_pass(bus.sum_i, bus.sum_q);
    pass_up   = pass_inc(pass_q);
    fail_up   = fail_inc(fail_q);

    case (state_q)
      ST_IDLE: begin
        cnt_nxt  = '0;
        pass_nxt = '0;
        fail_nxt = '0;
        if (bus.enable) begin
          state_nxt = ST_PULL_IN;
          clear_nxt = 1'b1;
        end
      end

      ST_PULL_IN, ST_LOCKED: begin
        if (!bus.enable) begin
          // Disable drops everything in flight; the filter is not cleared.
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          pass_nxt  = '0;
          fail_nxt  = '0;
        end else begin
          if (bus.sample_valid) begin
            if (cnt_q == CNT_W'(EPOCH_LEN - 1)) begin
              cnt_nxt  = '0;
              dump_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end

          if (bus.sum_valid) begin
            vld_nxt = 1'b1;
            if (state_q == ST_PULL_IN) begin
              if (!pass_p0) begin
                pass_nxt = '0;
              end else if (pass_up == PASS_W'(LOCK_COUNT)) begin
                state_nxt = ST_LOCKED;
                pass_nxt  = '0;
                fail_nxt  = '0;
              end else begin
                pass_nxt = pass_up;
              end
            end else begin
              if (pass_p0) begin
                fail_nxt = '0;
              end else if (fail_up == FAIL_W'(LOSS_COUNT)) begin
                // Lost lock: fall back to wide gains from a clean integrator,
                // keeping the sample counter so epoch alignment survives.
                state_nxt = ST_PULL_IN;
                pass_nxt  = '0;
                fail_nxt  = '0;
                clear_nxt = 1'b1;
              end else begin
                fail_nxt = fail_up;
              end
            end
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        pass_nxt  = '0;
        fail_nxt  = '0;
      end
    endcase
  end

  // ---- stage p0 -> p1: register state, counters and one-cycle strobes ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      dump_p1  <= 1'b0;
      clear_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      pass_q   <= pass_nxt;
      fail_q   <= fail_nxt;
      dump_p1  <= dump_nxt;
      clear_p1 <= clear_nxt;
      vld_p1   <= vld_nxt;
    end
  end

  assign bus.dump          = dump_p1;
  assign bus.filter_clear  = clear_p1;
  assign bus.filter_update = vld_p1;
  assign bus.state         = state_q;
  assign bus.locked        = (state_q == ST_LOCKED);
  assign bus.gain_sel      = (state_q == ST_LOCKED);

endmodule

// File: doc/costas_loop_ctrl.md
Name: costas_loop_ctrl

Overview:
- Epoch sequencer and lock supervisor for the Costas carrier loop.
- Counts input samples and issues the integrate-and-dump strobe to the I/Q summation blocks.
- Evaluates each dumped I/Q pair for phase lock and runs the acquisition/tracking state machine.
- Drives the loop filter: update strobe, clear, and wide/narrow gain select.

Parameters:
- EPOCH_LEN, 10000: samples per integration epoch; legal range 2..65535.
- LOCK_COUNT, 8: consecutive passing epochs needed to declare lock.
- LOSS_COUNT, 4: consecutive failing epochs while LOCKED that declare loss of lock.
- LOCK_SHIFT, 2: lock test passes when |I| > (|Q| << LOCK_SHIFT).
- MIN_AMP, 1024: minimum |I| for an epoch to pass.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  loop run request; level-sensitive.
- sample_valid  in  1  one new I/Q sample presented to the summation blocks this cycle.
- dump  out  1  one-cycle strobe; summation blocks output and restart their sums.
- sum_valid  in  1  sum_i/sum_q hold a completed epoch result.
- sum_i  in  32 signed  epoch I sum.
- sum_q  in  32 signed  epoch Q sum.
- filter_update  out  1  one-cycle strobe; loop filter consumes the phase error for this epoch.
- filter_clear  out  1  one-cycle strobe; loop filter zeroes its integrator.
- gain_sel  out  1  0 = wide (pull-in) gains, 1 = narrow (tracking) gains.
- locked  out  1  high while in LOCKED.
- state  out  2  00 IDLE, 01 PULL_IN, 10 LOCKED; 11 is unused.

Behaviour:
- Reset values (async): all outputs 0, state IDLE, sample counter 0, pass/fail counters 0.
- IDLE:
  - Sample counter held at 0; no dump, no filter_update.
  - sum_valid is ignored.
  - enable=1 moves to PULL_IN on the next edge and pulses filter_clear on that cycle.
- Sample counter (PULL_IN/LOCKED):
  - Increments on each sample_valid.
  - On the sample_valid where count==EPOCH_LEN-1, the counter wraps to 0 and dump is registered high for exactly the next cycle.
  - Back-to-back epochs have no dead cycle.
- Epoch evaluation on sum_valid (PULL_IN/LOCKED only):
  - abs computed at 33 bits; -2^31 yields 2^31 with no overflow.
  - |Q| << LOCK_SHIFT is computed at 33+LOCK_SHIFT bits.
  - pass = (|I| >= MIN_AMP) && (|I| > |Q|<<LOCK_SHIFT).
  - filter_update pulses the cycle after sum_valid, in every non-IDLE state and for pass or fail.
  - The state/counter update takes effect on that same cycle: 1-cycle latency.
- PULL_IN:
  - gain_sel=0.
  - pass increments pass_cnt; fail clears it.
  - When pass_cnt reaches LOCK_COUNT, go to LOCKED, clear pass_cnt, set gain_sel=1 and locked=1 on the transition cycle.
- LOCKED:
  - pass clears fail_cnt; fail increments it.
  - When fail_cnt reaches LOSS_COUNT, go to PULL_IN, clear both counters, drop gain_sel and locked, and pulse filter_clear.
  - Loss of lock does not reset the sample counter; epoch alignment is kept.
- enable=0 in any non-IDLE state:
  - Go to IDLE next edge; clear all counters.
  - A pending dump already registered still completes.
  - Any sum_valid arriving on or after the enable=0 cycle is ignored.
  - filter_clear is not pulsed.
- Simultaneous sample_valid and sum_valid: both are processed independently in the same cycle.
- sum_valid arriving more than once per epoch: each one is evaluated; the block does not police it.
- Counters saturate at LOCK_COUNT / LOSS_COUNT; no wrap.
- rst asserted mid-epoch: immediate return to reset values; no dump is issued.

Test Plan:
- Epoch timing, EPOCH_LEN=10, enable=1, sample_valid continuous -> one filter_clear at start; dump high on the cycle after the 10th, 20th and 30th samples; exactly 1 cycle wide each time.
- Lock acquisition: 8 epochs with sum_i=50000, sum_q=1000 -> filter_update after each; state 01→10 after the 8th; locked=1; gain_sel=1.
- Broken pass streak: 7 passes, one fail (sum_q=20000), then 8 passes -> lock only after the final 8th consecutive pass, i.e. 16 epochs total.
- Loss of lock: in LOCKED, 3 fails, 1 pass, 4 fails -> still locked after the pass; returns to PULL_IN after the 4th consecutive fail; filter_clear pulses once; gain_sel=0.
- Corner values:
  - sum_i=-2^31, sum_q=0 passes.
  - sum_i=1023, sum_q=0 fails on MIN_AMP.
  - sum_i=4000, sum_q=1000 fails, since the test is strict greater-than.
- Disable and reset mid-epoch:
  - enable drops at sample 5 of 10 -> IDLE; no dump; a later sum_valid produces no filter_update.
  - Re-enable -> counter restarts, so the first dump comes 10 samples later.
  - Async rst pulse between clk edges -> outputs clear immediately.
